// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_pkg
//  Description : Shared encodings for the multicycle MIPS control unit:
//                FSM state enum, opcode/funct codes, ALU F codes, aluop enum.
//                The BNEEX state exists only when MIPS_BNE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    // FSM states, 4-bit encoding
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
`ifdef MIPS_BNE_EN
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
`else
        S_JEX     = 4'd11
`endif
    } state_t;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU function codes (F)
    localparam logic [2:0] F_ADD = 3'b010;
    localparam logic [2:0] F_SUB = 3'b110;
    localparam logic [2:0] F_AND = 3'b000;
    localparam logic [2:0] F_OR  = 3'b001;
    localparam logic [2:0] F_SLT = 3'b111;

    // ALU operation class requested by the FSM
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

endpackage : mips_ctrl_pkg
`default_nettype wire

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl_if
//  Description : Control-unit <-> datapath bundle.
//                master : control unit (consumes op/funct/zero, drives controls)
//                slave  : datapath    (drives op/funct/zero, consumes controls)
//  Ports       : op[5:0], funct[5:0], zero                 (datapath -> ctrl)
//                iord, memwrite, irwrite, regdst, memtoreg,
//                regwrite, alusrca, alusrcb[1:0], pcsrc[1:0],
//                alucontrol[2:0], pcen                      (ctrl -> datapath)
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       pcen;

    modport master (
        input  op, funct, zero,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );

    modport slave (
        output op, funct, zero,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, alucontrol, pcen
    );
endinterface : mips_multicycle_ctrl_if
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : mips_alu_decoder
//  Description : Purely combinational (aluop, funct) -> ALU F code.
//  Ports       : i_aluop[1:0]      operation class from the FSM
//                i_funct[5:0]      R-type funct field
//                o_alucontrol[2:0] ALU F code
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
    import mips_ctrl_pkg::*;
(
    input  wire aluop_t     i_aluop,
    input  wire logic [5:0] i_funct,
    output logic      [2:0] o_alucontrol
);

    always_comb begin
        o_alucontrol = F_ADD;
        case (i_aluop)
            ALUOP_ADD: o_alucontrol = F_ADD;
            ALUOP_SUB: o_alucontrol = F_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = F_ADD;
                    FN_SUB:  o_alucontrol = F_SUB;
                    FN_AND:  o_alucontrol = F_AND;
                    FN_OR:   o_alucontrol = F_OR;
                    FN_SLT:  o_alucontrol = F_SLT;
                    // Unrecognised funct falls back to add; writeback still happens
                    default: o_alucontrol = F_ADD;
                endcase
            end
            default: o_alucontrol = F_ADD;
        endcase
    end

endmodule : mips_alu_decoder
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mips_multicycle_ctrl
//  Description : Moore FSM control unit for a multicycle MIPS datapath.
//                Sequences FETCH/DECODE/EXECUTE/MEM/WB and drives mux selects,
//                write enables and the ALU F code.
//                Optional: define MIPS_BNE_EN to add bne (opcode 000101).
//  Ports       : clk    rising-edge clock
//                reset  synchronous active-high; returns FSM to FETCH and,
//                       while high, forces write enables low and the other
//                       outputs to their FETCH values
//                bus    mips_multicycle_ctrl_if.master (op/funct/zero in,
//                       datapath controls out)
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    mips_multicycle_ctrl_if.master bus
);

    state_t     r_state;
    state_t     w_next_state;

    logic       w_iord;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regdst;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_pcsrc;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_branch_ne;
    aluop_t     w_aluop;
    logic [2:0] w_alucontrol;
    logic       w_pcen;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and Moore output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        w_iord       = 1'b0;
        w_memwrite   = 1'b0;
        w_irwrite    = 1'b0;
        w_regdst     = 1'b0;
        w_memtoreg   = 1'b0;
        w_regwrite   = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_pcsrc      = 2'b00;
        w_pcwrite    = 1'b0;
        w_branch     = 1'b0;
        w_branch_ne  = 1'b0;
        w_aluop      = ALUOP_ADD;

        case (r_state)
            S_FETCH: begin
                w_alusrcb    = 2'b01;
                w_irwrite    = 1'b1;
                w_pcwrite    = 1'b1;
                w_next_state = S_DECODE;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut
                w_alusrcb = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW: w_next_state = S_MEMADR;
                    OP_RTYPE:     w_next_state = S_RTYPEEX;
                    OP_BEQ:       w_next_state = S_BEQEX;
                    OP_ADDI:      w_next_state = S_ADDIEX;
                    OP_J:         w_next_state = S_JEX;
`ifdef MIPS_BNE_EN
                    OP_BNE:       w_next_state = S_BNEEX;
`endif
                    default:      w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = (bus.op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                w_iord       = 1'b1;
                w_next_state = S_MEMWB;
            end
            S_MEMWB: begin
                w_memtoreg   = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                w_iord       = 1'b1;
                w_memwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_RTYPEEX: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_FUNCT;
                w_next_state = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                w_regdst     = 1'b1;
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_BEQEX: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_SUB;
                w_pcsrc      = 2'b01;
                w_branch     = 1'b1;
                w_next_state = S_FETCH;
            end
`ifdef MIPS_BNE_EN
            S_BNEEX: begin
                w_alusrca    = 1'b1;
                w_aluop      = ALUOP_SUB;
                w_pcsrc      = 2'b01;
                w_branch_ne  = 1'b1;
                w_next_state = S_FETCH;
            end
`endif
            S_ADDIEX: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_regwrite   = 1'b1;
                w_next_state = S_FETCH;
            end
            S_JEX: begin
                w_pcsrc      = 2'b10;
                w_pcwrite    = 1'b1;
                w_next_state = S_FETCH;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

    mips_alu_decoder u_alu_decoder (
        .i_aluop      (w_aluop),
        .i_funct      (bus.funct),
        .o_alucontrol (w_alucontrol)
    );

`ifdef MIPS_BNE_EN
    assign w_pcen = w_pcwrite | (w_branch & bus.zero) | (w_branch_ne & ~bus.zero);
`else
    assign w_pcen = w_pcwrite | (w_branch & bus.zero);
`endif

    // ------------------------------------------------------------------
    // Output stage: while reset is held the datapath sees FETCH selects
    // with every write enable suppressed, whatever state was interrupted.
    // ------------------------------------------------------------------
    assign bus.iord       = reset ? 1'b0  : w_iord;
    assign bus.memwrite   = w_memwrite & ~reset;
    assign bus.irwrite    = w_irwrite  & ~reset;
    assign bus.regdst     = reset ? 1'b0  : w_regdst;
    assign bus.memtoreg   = reset ? 1'b0  : w_memtoreg;
    assign bus.regwrite   = w_regwrite & ~reset;
    assign bus.alusrca    = reset ? 1'b0  : w_alusrca;
    assign bus.alusrcb    = reset ? 2'b01 : w_alusrcb;
    assign bus.pcsrc      = reset ? 2'b00 : w_pcsrc;
    assign bus.alucontrol = reset ? F_ADD : w_alucontrol;
    assign bus.pcen       = w_pcen & ~reset;

endmodule : mips_multicycle_ctrl
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_multicycle_ctrl
//  Description : Self-checking bench for mips_multicycle_ctrl. Directed
//                instructions followed by a random instruction stream with
//                random zero flag and occasional mid-instruction resets.
//                Expected outputs come from a per-instruction cycle table.
//                Honours MIPS_BNE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_multicycle_ctrl;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
    //  alusrcb[1:0], pcsrc[1:0], alucontrol[2:0], pcen}
    logic [14:0] w_got;
    assign w_got = {bus.iord, bus.memwrite, bus.irwrite, bus.regdst, bus.memtoreg,
                    bus.regwrite, bus.alusrca, bus.alusrcb, bus.pcsrc,
                    bus.alucontrol, bus.pcen};

    localparam logic [14:0] RESET_VEC = {7'b0, 2'b01, 2'b00, 3'b010, 1'b0};

    task automatic check_vec(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    function automatic bit bne_on();
`ifdef MIPS_BNE_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    // Cycles from FETCH to the last cycle of the instruction
    function automatic int instr_len(input logic [5:0] op);
        case (op)
            6'b100011: return 5;
            6'b101011: return 4;
            6'b000000: return 4;
            6'b001000: return 4;
            6'b000100: return 3;
            6'b000010: return 3;
            6'b000101: return bne_on() ? 3 : 2;
            default:   return 2;
        endcase
    endfunction

    function automatic logic [2:0] funct_f(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected outputs in cycle c (0 = FETCH) of instruction op/fn
    function automatic logic [14:0] exp_vec(input logic [5:0] op, input logic [5:0] fn,
                                            input int c, input logic z);
        logic iord, mw, irw, rdst, m2r, rw, sa, pcen;
        logic [1:0] sb, ps;
        logic [2:0] f;
        iord = 0; mw = 0; irw = 0; rdst = 0; m2r = 0; rw = 0; sa = 0; pcen = 0;
        sb = 2'b00; ps = 2'b00; f = 3'b010;
        if (c == 0) begin
            irw = 1; sb = 2'b01; pcen = 1;
        end else if (c == 1) begin
            sb = 2'b11;
        end else begin
            case (op)
                6'b100011, 6'b101011: begin
                    if (c == 2) begin sa = 1; sb = 2'b10; end
                    else if (c == 3 && op == 6'b100011) iord = 1;
                    else if (c == 3) begin iord = 1; mw = 1; end
                    else begin m2r = 1; rw = 1; end
                end
                6'b000000: begin
                    if (c == 2) begin sa = 1; f = funct_f(fn); end
                    else begin rdst = 1; rw = 1; end
                end
                6'b001000: begin
                    if (c == 2) begin sa = 1; sb = 2'b10; end
                    else rw = 1;
                end
                6'b000100: begin sa = 1; f = 3'b110; ps = 2'b01; pcen = z; end
                6'b000101: begin sa = 1; f = 3'b110; ps = 2'b01; pcen = ~z; end
                6'b000010: begin ps = 2'b10; pcen = 1; end
                default: ;
            endcase
        end
        return {iord, mw, irw, rdst, m2r, rw, sa, sb, ps, f, pcen};
    endfunction

    // Entered and left at posedge+1
    task automatic do_reset(input string why);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus.zero = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_vec($sformatf("%s_reset_cyc%0d", why, k), w_got, RESET_VEC);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // zmode: 0/1 fixed zero value, 2 random per cycle. abort_at < 0: no abort.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_at);
        int n;
        bus.op    = op;
        bus.funct = fn;
        n = instr_len(op);
        for (int c = 0; c < n; c++) begin
            if (c == abort_at) begin
                do_reset($sformatf("abort_op%b", op));
                return;
            end
            bus.zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            @(negedge clk);
            check_vec($sformatf("op%b_fn%b_z%0b_cyc%0d", op, fn, bus.zero, c),
                      w_got, exp_vec(op, fn, c, bus.zero));
            @(posedge clk); #1;
        end
    endtask

    logic [5:0] op_tab [0:7];
    logic [5:0] fn_tab [0:4];

    initial begin
        n_vec = 0;
        n_err = 0;
        op_tab[0] = 6'b100011; op_tab[1] = 6'b101011; op_tab[2] = 6'b000000;
        op_tab[3] = 6'b000100; op_tab[4] = 6'b000101; op_tab[5] = 6'b001000;
        op_tab[6] = 6'b000010; op_tab[7] = 6'b111111;
        fn_tab[0] = 6'b100000; fn_tab[1] = 6'b100010; fn_tab[2] = 6'b100100;
        fn_tab[3] = 6'b100101; fn_tab[4] = 6'b101010;

        bus.op    = 6'b0;
        bus.funct = 6'b0;
        bus.zero  = 1'b0;
        reset     = 1'b1;
        do_reset("power_on");

        // Directed cases
        run_instr(6'b100011, 6'b000000, 2, 4);   // lw aborted by reset in MEMWB
        run_instr(6'b100011, 6'b000000, 2, -1);  // lw
        run_instr(6'b000000, 6'b101010, 2, -1);  // slt
        run_instr(6'b000000, 6'b100010, 2, -1);  // sub
        run_instr(6'b000000, 6'b111000, 2, -1);  // unknown funct -> add
        run_instr(6'b000100, 6'b000000, 1, -1);  // beq taken
        run_instr(6'b000100, 6'b000000, 0, -1);  // beq not taken
        run_instr(6'b101011, 6'b000000, 2, -1);  // sw
        run_instr(6'b000010, 6'b000000, 2, -1);  // j
        run_instr(6'b001000, 6'b000000, 2, -1);  // addi
        run_instr(6'b111111, 6'b000000, 2, -1);  // unknown op
        run_instr(6'b000101, 6'b000000, 0, -1);  // bne / NOP
        run_instr(6'b000101, 6'b000000, 1, -1);

        // Random stream
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int ab;
            int sel;
            sel = $urandom_range(0, 9);
            op  = (sel < 8) ? op_tab[sel] : 6'($urandom);
            fn  = ($urandom_range(0, 3) != 0) ? fn_tab[$urandom_range(0, 4)] : 6'($urandom);
            ab  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, instr_len(op) - 1) : -1;
            run_instr(op, fn, 2, ab);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_multicycle_ctrl
`default_nettype wire

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle MIPS control unit that sits directly upstream of the ALU and the rest of the datapath.
- A Moore state machine sequences each instruction through fetch, decode, execute, memory and writeback cycles.
- It drives the datapath mux selects and write enables.
- It generates the 3-bit ALU function code `F` (`alucontrol`) from the opcode and funct fields, and consumes the ALU `zero` flag to resolve branches.

## Interface
Parameters:
- none; all encodings are fixed by the MIPS ISA subset.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high; state returns to FETCH
- `op`  in  6  instr[31:26] from the instruction register
- `funct`  in  6  instr[5:0] from the instruction register
- `zero`  in  1  ALU zero flag (`Y==0`)
- `iord`  out  1  memory address select: 0=PC, 1=ALUOut
- `memwrite`  out  1  data memory write enable
- `irwrite`  out  1  instruction register load
- `regdst`  out  1  write register select: 0=rt, 1=rd
- `memtoreg`  out  1  writeback data select: 0=ALUOut, 1=Data
- `regwrite`  out  1  register file write enable
- `alusrca`  out  1  ALU A select: 0=PC, 1=register A
- `alusrcb`  out  2  ALU B select: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
- `pcsrc`  out  2  PC source: 00=ALUResult, 01=ALUOut, 10=jump target
- `alucontrol`  out  3  ALU `F`: 010 add, 110 sub, 000 and, 001 or, 111 slt
- `pcen`  out  1  PC register enable

## Operation
States:
- FETCH: `iord=0`, `alusrca=0`, `alusrcb=01`, aluop=add, `pcsrc=00`, `irwrite=1`, pcwrite=1 -> DECODE
- DECODE: `alusrca=0`, `alusrcb=11`, aluop=add (branch target into ALUOut). Next state by `op`:
  - lw/sw -> MEMADR
  - R-type -> RTYPEEX
  - beq -> BEQEX
  - addi -> ADDIEX
  - j -> JEX
  - any other opcode -> FETCH (treated as NOP)
- MEMADR: `alusrca=1`, `alusrcb=10`, add -> MEMRD (lw) or MEMWR (sw)
- MEMRD: `iord=1` -> MEMWB
- MEMWB: `regdst=0`, `memtoreg=1`, `regwrite=1` -> FETCH
- MEMWR: `iord=1`, `memwrite=1` -> FETCH
- RTYPEEX: `alusrca=1`, `alusrcb=00`, aluop=funct -> RTYPEWB
- RTYPEWB: `regdst=1`, `memtoreg=0`, `regwrite=1` -> FETCH
- BEQEX: `alusrca=1`, `alusrcb=00`, aluop=sub, `pcsrc=01`, branch=1 -> FETCH
- ADDIEX: `alusrca=1`, `alusrcb=10`, add -> ADDIWB
- ADDIWB: `regdst=0`, `memtoreg=0`, `regwrite=1` -> FETCH
- JEX: `pcsrc=10`, pcwrite=1 -> FETCH

Output rules:
- Any output not listed for a state is 0, or 00 for 2-bit selects.
- `pcen = pcwrite | (branch & zero)`.
- ALU decode:
  - aluop add -> 010; aluop sub -> 110.
  - aluop funct: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111.
  - Unknown funct -> 010 (add); RTYPEWB still writes.

## Timing
- All outputs are combinational decodes of the state register only (Moore). `pcen` additionally depends on `zero` in BEQEX/BNEEX.
- State register updates on the rising edge of `clk`.
- Reset:
  - With `reset=1` at a clock edge, state <= FETCH, regardless of the current state (mid-instruction aborts cleanly).
  - While `reset` is high, `irwrite`, `memwrite`, `regwrite` and `pcen` are forced 0. All other outputs take their FETCH values (`alucontrol=010`, `alusrcb=01`, rest 0).
- Instruction latency in cycles, FETCH inclusive:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
  - unknown opcode 2
- `op` and `funct` must be stable from DECODE through the end of the instruction. The IR is only loaded in FETCH.

## Configuration
- `MIPS_BNE_EN` defined:
  - Adds opcode 000101 (bne): DECODE -> BNEEX.
  - BNEEX drives the same outputs as BEQEX, but asserts branch_ne instead of branch.
  - `pcen = pcwrite | (branch & zero) | (branch_ne & ~zero)`.
- `MIPS_BNE_EN` undefined: opcode 000101 is unknown (2-cycle NOP), and BNEEX does not exist.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum typedef (4-bit encoding);
  - opcode localparams: LW 100011, SW 101011, RTYPE 000000, BEQ 000100, BNE 000101, ADDI 001000, J 000010;
  - funct localparams;
  - ALU `F` code localparams;
  - the 2-bit aluop typedef.
- One sub-module, `mips_alu_decoder`: purely combinational (aluop, funct) -> `alucontrol`. It is instantiated once inside `mips_multicycle_ctrl`.

## Test plan
- Reset held 2 cycles mid-MEMWB of a lw -> all write enables 0 during reset; first cycle after release is FETCH with `irwrite=1`, `pcen=1`, `alucontrol=010`.
- lw (`op`=100011) -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regwrite=1` and `memtoreg=1` only in cycle 5; back in FETCH at cycle 6.
- R-type slt (`funct`=101010) -> `alucontrol=111` in RTYPEEX; `regdst=1`, `regwrite=1` in RTYPEWB; 4 cycles total. Repeat for funct 100010 -> 110.
- beq with `zero=1` -> `pcen=1` and `pcsrc=01` in cycle 3. beq with `zero=0` -> `pcen=0` in cycle 3; both return to FETCH.
- sw (`op`=101011) -> `memwrite=1`, `iord=1` only in cycle 4, `regwrite` never asserted. j (`op`=000010) -> `pcsrc=10`, `pcen=1` in cycle 3.
- Unknown `op`=111111 -> 2-cycle NOP with no write enables beyond FETCH. With `MIPS_BNE_EN`: `op`=000101 and `zero=0` -> `pcen=1` in BNEEX; `zero=1` -> `pcen=0`.
